// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch controller. Drives the PC block's reset/increment/load
//               controls, runs the imem request/ack handshake at the current
//               PC, and hands fetched words to decode over valid/ready. Also
//               handles branch redirects, halt/resume and a fetch timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_in,
  output logic              pc_read,
  output logic              pc_inc,
  output logic              pc_reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  input  logic              resume,
  output logic              fault,
  output logic [2:0]        state_o
);

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int               CNT_W      = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RST      = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_REDIRECT = 3'd3,
    S_HALT     = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_pend_br;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_fault;

  logic              w_branch_cap;
  logic              w_squash;
  logic              w_accept;

  // Branch capture window and the issue-stage squash/accept decisions.
  always_comb begin
    w_branch_cap = 1'b0;
    w_squash     = 1'b0;
    w_accept     = 1'b0;
    if (branch_valid &&
        (r_state == S_FETCH || r_state == S_ISSUE || r_state == S_HALT)) begin
      w_branch_cap = 1'b1;
    end
    if (r_state == S_ISSUE) begin
      // A branch (pending or arriving now) wins over decode accepting.
      w_squash = r_pend_br | branch_valid;
      w_accept = ~w_squash & instr_ready;
    end
  end

  assign pc_in       = r_pend_tgt;
  assign pc_read     = (r_state != S_REDIRECT);
  assign pc_inc      = w_accept;
  assign pc_reset    = (r_state == S_RST);
  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = imem_req ? pc_out : '0;
  assign instr_valid = (r_state == S_ISSUE);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fault       = r_fault;
  assign state_o     = r_state;

  // Sequencer state, pending branch, timeout counter and issue registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_RST;
      r_pend_br  <= 1'b0;
      r_pend_tgt <= '0;
      r_cnt      <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_fault    <= 1'b0;
    end else begin
      // Latest branch wins; REDIRECT is outside the capture window so the
      // clear below never collides with a capture.
      if (w_branch_cap) begin
        r_pend_br  <= 1'b1;
        r_pend_tgt <= branch_target;
      end
      case (r_state)
        S_RST: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_cnt <= '0;
            if (r_pend_br) begin
              // Word fetched from the stale path is dropped.
              r_state <= S_REDIRECT;
            end else begin
              r_instr    <= imem_data;
              r_instr_pc <= pc_out;
              r_state    <= S_ISSUE;
            end
          end else if (r_cnt == C_CNT_LAST) begin
            r_cnt   <= '0;
            r_fault <= 1'b1;
            r_state <= S_FAULT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (w_squash) begin
            r_state <= S_REDIRECT;
          end else if (instr_ready) begin
            r_state <= halt ? S_HALT : S_FETCH;
          end
        end
        S_REDIRECT: begin
          r_pend_br <= 1'b0;
          r_state   <= S_FETCH;
        end
        S_HALT: begin
          if (resume) begin
            r_state <= r_pend_br ? S_REDIRECT : S_FETCH;
          end
        end
        S_FAULT: begin
          r_fault <= 1'b1;
        end
        default: begin
          r_state <= S_RST;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer with a PC block model,
//               an imem responder and an issue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  localparam logic [2:0] C_RST = 3'd0, C_FETCH = 3'd1, C_ISSUE = 3'd2,
                         C_REDIR = 3'd3, C_HALT = 3'd4, C_FAULT = 3'd5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_read, pc_inc, pc_reset;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [DATA_W-1:0] imem_data = '0;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready = 1'b0;
  logic              branch_valid = 1'b0;
  logic [ADDR_W-1:0] branch_target = '0;
  logic              halt = 1'b0;
  logic              resume = 1'b0;
  logic              fault;
  logic [2:0]        state_o;

  int n_checks = 0;
  int n_errors = 0;

  // Bench models
  logic [ADDR_W-1:0] pc_model = 'x;
  int                ack_lat  = 1;
  int                req_cnt  = 0;
  logic              mem_mute = 1'b0;
  logic              br_pend_model = 1'b0;
  logic [ADDR_W-1:0] exp_tgt = '0;
  logic [ADDR_W-1:0] exp_pc_q[$];
  logic [DATA_W-1:0] exp_ins_q[$];

  pc_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .pc_in(pc_in),
    .pc_read(pc_read), .pc_inc(pc_inc), .pc_reset(pc_reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .halt(halt), .resume(resume), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign pc_out = pc_model;

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state_o !== s && n < budget) begin
      tick();
      n++;
    end
    check("wait_state", {61'd0, state_o}, {61'd0, s});
  endtask

  // PC block model: clear > load > increment, step 1.
  always @(posedge clk) begin
    if (pc_reset === 1'b1)      pc_model <= '0;
    else if (pc_read === 1'b0)  pc_model <= pc_in;
    else if (pc_inc === 1'b1)   pc_model <= pc_model + 1;
  end

  // Instruction memory: ack after ack_lat idle request cycles.
  always @(posedge clk) begin
    #1;
    if (imem_req === 1'b1 && !mem_mute) begin
      if (req_cnt >= ack_lat) begin
        imem_ack  = 1'b1;
        imem_data = word_of(imem_addr);
        req_cnt   = 0;
      end else begin
        imem_ack = 1'b0;
        req_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      req_cnt  = 0;
    end
  end

  // Monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    check("imem_addr", imem_addr, (imem_req === 1'b1) ? pc_model : '0);
    check("inc_load_excl", {63'd0, (pc_inc & ~pc_read)}, 64'd0);
    if (reset) begin
      exp_pc_q.delete();
      exp_ins_q.delete();
      br_pend_model = 1'b0;
    end else begin
      if (instr_valid === 1'b1) begin
        if (branch_valid || br_pend_model) begin
          check("squash_no_inc", {63'd0, pc_inc}, 64'd0);
          if (exp_pc_q.size() > 0) begin
            void'(exp_pc_q.pop_front());
            void'(exp_ins_q.pop_front());
          end
        end else if (instr_ready) begin
          check("accept_inc", {63'd0, pc_inc}, 64'd1);
          if (exp_pc_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
          end else begin
            check("instr_pc", instr_pc, exp_pc_q.pop_front());
            check("instr", instr, exp_ins_q.pop_front());
          end
        end
      end
      if (imem_req === 1'b1 && imem_ack && !br_pend_model) begin
        exp_pc_q.push_back(pc_model);
        exp_ins_q.push_back(word_of(pc_model));
      end
      if (pc_read === 1'b0) begin
        check("redirect_pc_in", pc_in, exp_tgt);
        br_pend_model = 1'b0;
      end
      if (branch_valid) begin
        br_pend_model = 1'b1;
        exp_tgt       = branch_target;
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] held;
    logic [ADDR_W-1:0] p;
    logic              saw;
    int                n;

    // 1: reset and first fetch
    instr_ready = 1'b1;
    ack_lat     = 1;
    tick();
    check("rst_state", state_o, C_RST);
    check("rst_pc_reset", pc_reset, 1);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_fault", fault, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    tick();
    reset = 1'b0;
    tick();
    check("first_state", state_o, C_FETCH);
    check("first_addr", imem_addr, 0);
    wait_state(C_ISSUE, 10);
    check("first_instr_pc", instr_pc, 0);
    check("first_instr", instr, word_of(0));
    check("first_inc", pc_inc, 1);
    tick();
    check("second_addr", imem_addr, 1);

    // 2: back-pressure
    instr_ready = 1'b0;
    wait_state(C_ISSUE, 10);
    held = instr;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", instr_valid, 1);
      check("bp_instr", instr, held);
      check("bp_no_inc", pc_inc, 0);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    check("bp_accept_inc", pc_inc, 1);
    p = pc_model;
    tick();
    check("bp_pc_step", pc_model, p + 1);
    check("bp_state", state_o, C_FETCH);

    // 3a: branch in ISSUE beats instr_ready
    wait_state(C_ISSUE, 10);
    branch_valid  = 1'b1;
    branch_target = 132;
    #1;
    check("br_issue_no_inc", pc_inc, 0);
    tick();
    branch_valid = 1'b0;
    ack_lat      = 3;
    #1;
    check("br_redir_state", state_o, C_REDIR);
    check("br_pc_read", pc_read, 0);
    check("br_pc_in", pc_in, 132);
    tick();
    check("br_fetch_addr", imem_addr, 132);

    // 3b: branch during a slow fetch
    tick();
    branch_valid  = 1'b1;
    branch_target = 300;
    tick();
    branch_valid = 1'b0;
    saw = 1'b0;
    n   = 0;
    while (state_o !== C_REDIR && n < 10) begin
      if (instr_valid) saw = 1'b1;
      tick();
      n++;
    end
    check("brf_redir_state", state_o, C_REDIR);
    check("brf_no_issue", saw, 0);
    check("brf_pc_in", pc_in, 300);
    ack_lat = 4;
    tick();
    check("brf_fetch_addr", imem_addr, 300);

    // 4: two branches during one fetch, latest wins
    tick();
    branch_valid  = 1'b1;
    branch_target = 40;
    tick();
    branch_target = 80;
    tick();
    branch_valid = 1'b0;
    wait_state(C_REDIR, 10);
    check("br2_pc_in", pc_in, 80);
    ack_lat = 1;
    tick();
    check("br2_fetch_addr", imem_addr, 80);

    // 6: halt at accept, branch while halted, resume
    halt = 1'b1;
    wait_state(C_ISSUE, 10);
    check("halt_inc", pc_inc, 1);
    p = pc_model;
    tick();
    halt = 1'b0;
    #1;
    check("halt_state", state_o, C_HALT);
    check("halt_req", imem_req, 0);
    check("halt_valid", instr_valid, 0);
    check("halt_pc", pc_model, p + 1);
    tick();
    tick();
    check("halt_stay", state_o, C_HALT);
    branch_valid  = 1'b1;
    branch_target = 200;
    tick();
    branch_valid = 1'b0;
    resume       = 1'b1;
    #1;
    check("halt_before_resume", state_o, C_HALT);
    tick();
    resume = 1'b0;
    #1;
    check("resume_redir", state_o, C_REDIR);
    check("resume_pc_in", pc_in, 200);
    tick();
    check("resume_state", state_o, C_FETCH);
    check("resume_addr", imem_addr, 200);

    // 5: fetch timeout
    mem_mute = 1'b1;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      check("to_still_fetch", state_o, C_FETCH);
    end
    tick();
    check("to_state", state_o, C_FAULT);
    check("to_fault", fault, 1);
    check("to_req", imem_req, 0);
    branch_valid  = 1'b1;
    branch_target = 5;
    tick();
    branch_valid = 1'b0;
    tick();
    check("to_sticky_state", state_o, C_FAULT);
    check("to_sticky_fault", fault, 1);
    check("to_no_load", pc_read, 1);
    reset    = 1'b1;
    mem_mute = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("to_rst_state", state_o, C_RST);
    check("to_rst_fault", fault, 0);
    check("to_rst_pc_reset", pc_reset, 1);
    tick();
    check("to_refetch_state", state_o, C_FETCH);
    check("to_refetch_addr", imem_addr, 0);
    wait_state(C_ISSUE, 10);
    check("to_refetch_instr_pc", instr_pc, 0);
    tick();
    tick();
    check("sb_drained", exp_pc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
